// File: rtl/mbs_bus_tracer.sv
// Bus transaction tracer for the MBSsoc buses: keeps a circular pre-trigger history,
// captures a fixed post-trigger window on an address match, then drains via valid/ready.
module mbs_bus_tracer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POST_CNT = 8,
  parameter int unsigned TS_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [31:0]            trig_addr,
  input  logic [31:0]            trig_mask,
  input  logic [31:0]            addr_bus,
  input  logic [31:0]            data_bus,
  input  logic [31:0]            ctrl_bus,
  input  logic                   cpu_sel,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [31:0]            trc_addr,
  output logic [31:0]            trc_data,
  output logic                   trc_we,
  output logic                   trc_cpu,
  output logic [TS_W-1:0]        trc_ts,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (POST_CNT > 0) ? $clog2(POST_CNT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [RW-1:0] POST_INIT = RW'(POST_CNT);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic            cpu;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } entry_t;

  state_e          state_q;
  logic [RW-1:0]   rem_q;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  entry_t          mem [DEPTH];

  logic   qual;
  logic   hit;
  logic   full;
  logic   empty;
  logic   readable;
  logic   flush;
  logic   push;
  logic   pop;
  logic   ovf_set;
  entry_t new_entry;
  entry_t head;

  // Only the two strobe bits of the control bus are meaningful here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_bus[31:2];

  assign qual     = ctrl_bus[0] | ctrl_bus[1];
  assign hit      = qual && (((addr_bus ^ trig_addr) & trig_mask) == 32'h0);
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign readable = (state_q == StIdle) || (state_q == StDone);

  assign new_entry = '{cpu: cpu_sel, we: ctrl_bus[1], addr: addr_bus, data: data_bus, ts: ts_q};

  always_comb begin
    flush   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          flush = 1'b1;
        end else if (trc_valid && trc_ready) begin
          pop = 1'b1;
        end
      end
      StArmed: begin
        // A full history drops its oldest entry so the newest always fits.
        if (qual) begin
          push = 1'b1;
          pop  = full;
        end
      end
      StPost: begin
        if (qual) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_q    <= StArmed;
            overflow_q <= 1'b0;
          end
        end
        StArmed: begin
          if (hit) begin
            if (POST_CNT == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StPost;
              rem_q   <= POST_INIT;
            end
          end
        end
        StPost: begin
          // Dropped transactions still consume the post-trigger window.
          if (qual) begin
            rem_q <= rem_q - RW'(1);
            if (ovf_set) begin
              overflow_q <= 1'b1;
            end
            if (rem_q == RW'(1)) begin
              state_q <= StDone;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign head      = mem[rd_ptr_q];
  assign trc_valid = readable && !empty;
  assign trc_addr  = empty ? 32'h0 : head.addr;
  assign trc_data  = empty ? 32'h0 : head.data;
  assign trc_we    = empty ? 1'b0 : head.we;
  assign trc_cpu   = empty ? 1'b0 : head.cpu;
  assign trc_ts    = empty ? '0 : head.ts;
  assign state     = state_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mbs_bus_tracer.sv
// Testbench for mbs_bus_tracer: two instances (POST_CNT = 8 and 0) share one stimulus
// stream and are checked against a queue-based reference model of the tracer.
module tb_mbs_bus_tracer;

  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SW    = CW + 4;

  typedef struct packed {
    logic            cpu;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, arm, cpu_sel, trc_ready;
  logic [31:0] trig_addr, trig_mask, addr_bus, data_bus, ctrl_bus;

  logic            trc_valid [2];
  logic [31:0]     trc_addr  [2];
  logic [31:0]     trc_data  [2];
  logic            trc_we    [2];
  logic            trc_cpu   [2];
  logic [TS_W-1:0] trc_ts    [2];
  logic [1:0]      state     [2];
  logic [CW-1:0]   count     [2];
  logic            overflow  [2];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: one entry queue and phase per instance.
  int              post_cnt [2] = '{8, 0};
  int              m_state  [2] = '{0, 0};
  int              m_rem    [2] = '{0, 0};
  bit              m_ovf    [2] = '{0, 0};
  ent_t            m_q      [2][$];
  logic [TS_W-1:0] m_ts = '0;

  always #5 clk = ~clk;

  mbs_bus_tracer #(.DEPTH(DEPTH), .POST_CNT(8), .TS_W(TS_W)) u_dut8 (
    .clk(clk), .rst(rst), .arm(arm), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .addr_bus(addr_bus), .data_bus(data_bus), .ctrl_bus(ctrl_bus), .cpu_sel(cpu_sel),
    .trc_valid(trc_valid[0]), .trc_ready(trc_ready), .trc_addr(trc_addr[0]),
    .trc_data(trc_data[0]), .trc_we(trc_we[0]), .trc_cpu(trc_cpu[0]), .trc_ts(trc_ts[0]),
    .state(state[0]), .count(count[0]), .overflow(overflow[0])
  );

  mbs_bus_tracer #(.DEPTH(DEPTH), .POST_CNT(0), .TS_W(TS_W)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .addr_bus(addr_bus), .data_bus(data_bus), .ctrl_bus(ctrl_bus), .cpu_sel(cpu_sel),
    .trc_valid(trc_valid[1]), .trc_ready(trc_ready), .trc_addr(trc_addr[1]),
    .trc_data(trc_data[1]), .trc_we(trc_we[1]), .trc_cpu(trc_cpu[1]), .trc_ts(trc_ts[1]),
    .state(state[1]), .count(count[1]), .overflow(overflow[1])
  );

  function automatic ent_t exp_head(int k);
    if (m_q[k].size() == 0) return '0;
    return m_q[k][0];
  endfunction

  function automatic logic [SW-1:0] exp_stat(int k);
    logic [1:0]    s;
    logic [CW-1:0] c;
    logic          v;
    s = 2'(m_state[k]);
    c = CW'(m_q[k].size());
    v = (m_state[k] == 0 || m_state[k] == 3) && (m_q[k].size() != 0);
    return {s, c, m_ovf[k], v};
  endfunction

  function automatic ent_t obs_head(int k);
    return {trc_cpu[k], trc_we[k], trc_addr[k], trc_data[k], trc_ts[k]};
  endfunction

  function automatic logic [SW-1:0] obs_stat(int k);
    return {state[k], count[k], overflow[k], trc_valid[k]};
  endfunction

  // Advance one clock: update the model from the current inputs, then let the DUTs see the edge.
  task automatic tick();
    bit   qual, hit;
    ent_t e;
    qual = ctrl_bus[0] | ctrl_bus[1];
    hit  = qual && (((addr_bus ^ trig_addr) & trig_mask) == 32'h0);
    e    = '{cpu: cpu_sel, we: ctrl_bus[1], addr: addr_bus, data: data_bus, ts: m_ts};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0;
        m_rem[k]   = 0;
        m_ovf[k]   = 0;
        m_q[k].delete();
      end else begin
        case (m_state[k])
          0, 3: begin
            if (arm) begin
              m_q[k].delete();
              m_ovf[k]   = 0;
              m_state[k] = 1;
            end else if (trc_ready && m_q[k].size() > 0) begin
              void'(m_q[k].pop_front());
            end
          end
          1: begin
            if (qual) begin
              if (m_q[k].size() == DEPTH) void'(m_q[k].pop_front());
              m_q[k].push_back(e);
              if (hit) begin
                m_rem[k]   = post_cnt[k];
                m_state[k] = (post_cnt[k] == 0) ? 3 : 2;
              end
            end
          end
          default: begin
            if (qual) begin
              if (m_q[k].size() == DEPTH) m_ovf[k] = 1;
              else m_q[k].push_back(e);
              m_rem[k]--;
              if (m_rem[k] == 0) m_state[k] = 3;
            end
          end
        endcase
      end
    end
    m_ts = rst ? '0 : m_ts + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] c, input logic [31:0] a);
    ctrl_bus = {30'h0, c};
    addr_bus = a;
    data_bus = $urandom;
    cpu_sel  = 1'($urandom_range(0, 1));
    tick();
    ctrl_bus = '0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    arm       = 1'b0;
    ctrl_bus  = '0;
    trc_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stat(k) !== {SW{1'b0}}) begin
        n_fails++;
        $display("FAIL reset_stat dut%0d: got %h want 0", k, obs_stat(k));
      end
      n_checks++;
      if (obs_head(k) !== '0) begin
        n_fails++;
        $display("FAIL reset_head dut%0d: got %h want 0", k, obs_head(k));
      end
    end
  endtask

  task automatic test_trigger();
    do_reset();
    trig_addr = 32'h14;
    trig_mask = 32'hFFFF_FFFF;
    pulse_arm();
    bus(2'b10, 32'h10);
    bus(2'b10, 32'h14);
    n_checks++;
    if (state[0] !== 2'd2) begin
      n_fails++;
      $display("FAIL trig_state: got %0d want 2", state[0]);
    end
    bus(2'b10, 32'h18);
    n_checks++;
    if (count[0] !== CW'(3)) begin
      n_fails++;
      $display("FAIL trig_count: got %0d want 3", count[0]);
    end
    for (int i = 0; i < 7; i++) bus(2'b10, 32'h20 + 32'(4 * i));
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stat(k) !== exp_stat(k)) begin
        n_fails++;
        $display("FAIL trig_done dut%0d: got %h want %h", k, obs_stat(k), exp_stat(k));
      end
    end
  endtask

  task automatic test_drain();
    ctrl_bus  = '0;
    trc_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH && (m_q[0].size() != 0 || m_q[1].size() != 0); i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_head(k) !== exp_head(k) || obs_stat(k) !== exp_stat(k)) begin
          n_fails++;
          $display("FAIL drain dut%0d: got %h/%h want %h/%h", k, obs_head(k), obs_stat(k),
                   exp_head(k), exp_stat(k));
        end
      end
      tick();
    end
    trc_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stat(k) !== exp_stat(k)) begin
        n_fails++;
        $display("FAIL drain_end dut%0d: got %h want %h", k, obs_stat(k), exp_stat(k));
      end
    end
  endtask

  task automatic test_history();
    do_reset();
    trig_addr = 32'hFFF0_0000;
    trig_mask = 32'hFFFF_FFFF;
    pulse_arm();
    for (int i = 0; i < 20; i++) bus(2'b01, 32'h100 + 32'(4 * i));
    bus(2'b01, 32'hFFF0_0000);
    for (int i = 0; i < 8; i++) bus(2'b01, 32'h200 + 32'(4 * i));
    n_checks++;
    if (count[0] !== CW'(DEPTH) || overflow[0] !== 1'b1) begin
      n_fails++;
      $display("FAIL hist_full: got count %0d ovf %b want 16 1", count[0], overflow[0]);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stat(k) !== exp_stat(k) || obs_head(k) !== exp_head(k)) begin
        n_fails++;
        $display("FAIL hist dut%0d: got %h/%h want %h/%h", k, obs_stat(k), obs_head(k),
                 exp_stat(k), exp_head(k));
      end
    end
  endtask

  task automatic test_post0();
    logic [31:0] last;
    do_reset();
    trig_addr = 32'h4000_0040;
    trig_mask = 32'hFFFF_FFFF;
    pulse_arm();
    bus(2'b01, 32'h4000_0000);
    bus(2'b01, 32'h4000_0004);
    bus(2'b01, 32'h4000_0040);
    n_checks++;
    if (state[1] !== 2'd3 || trc_valid[1] !== 1'b1) begin
      n_fails++;
      $display("FAIL post0_done: got state %0d valid %b want 3 1", state[1], trc_valid[1]);
    end
    last      = '0;
    trc_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && m_q[1].size() != 0; i++) begin
      n_checks++;
      if (obs_head(1) !== exp_head(1)) begin
        n_fails++;
        $display("FAIL post0_head: got %h want %h", obs_head(1), exp_head(1));
      end
      if (trc_valid[1]) last = trc_addr[1];
      tick();
    end
    trc_ready = 1'b0;
    n_checks++;
    if (last !== 32'h4000_0040 || count[1] !== '0) begin
      n_fails++;
      $display("FAIL post0_last: got %h cnt %0d want 40000040 0", last, count[1]);
    end
  endtask

  task automatic test_write_mask();
    do_reset();
    trig_addr = 32'h2000_0000;
    trig_mask = 32'hFFFF_FF00;
    pulse_arm();
    bus(2'b11, 32'h2000_0100);
    n_checks++;
    if (state[0] !== 2'd1) begin
      n_fails++;
      $display("FAIL mask_miss: got state %0d want 1", state[0]);
    end
    bus(2'b11, 32'h2000_00AC);
    n_checks++;
    if (state[0] !== 2'd2 || state[1] !== 2'd3 || trc_we[1] !== 1'b1) begin
      n_fails++;
      $display("FAIL mask_hit: got st %0d/%0d we %b want 2/3 1", state[0], state[1], trc_we[1]);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_head(k) !== exp_head(k)) begin
        n_fails++;
        $display("FAIL mask_head dut%0d: got %h want %h", k, obs_head(k), exp_head(k));
      end
    end
    for (int i = 0; i < 8; i++) bus(2'($urandom_range(1, 3)), $urandom);
  endtask

  task automatic test_stall();
    ent_t snap;
    int   pops;
    do_reset();
    trig_addr = 32'h3000_0000;
    trig_mask = 32'hFFFF_FFFF;
    pulse_arm();
    for (int i = 0; i < 3; i++) bus(2'b01, 32'h3000_0010 + 32'(4 * i));
    bus(2'b10, 32'h3000_0000);
    snap = exp_head(1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_head(1) !== snap || trc_valid[1] !== 1'b1 || count[1] !== CW'(4)) begin
        n_fails++;
        $display("FAIL stall cyc%0d: got %h v%b c%0d want %h v1 c4", i, obs_head(1),
                 trc_valid[1], count[1], snap);
      end
      tick();
    end
    pops      = 0;
    trc_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (trc_valid[1]) pops++;
      tick();
    end
    trc_ready = 1'b0;
    n_checks++;
    if (pops != 4 || count[1] !== '0 || trc_valid[1] !== 1'b0) begin
      n_fails++;
      $display("FAIL stall_pops: got %0d cnt %0d want 4 0", pops, count[1]);
    end
  endtask

  task automatic test_reset_post();
    do_reset();
    trig_addr = 32'h50;
    trig_mask = 32'hFFFF_FFFF;
    pulse_arm();
    for (int i = 0; i < DEPTH; i++) bus(2'b10, 32'h1000 + 32'(4 * i));
    bus(2'b10, 32'h50);
    bus(2'b10, 32'h60);
    n_checks++;
    if (state[0] !== 2'd2 || overflow[0] !== 1'b1) begin
      n_fails++;
      $display("FAIL rpost_pre: got st %0d ovf %b want 2 1", state[0], overflow[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stat(k) !== {SW{1'b0}} || obs_head(k) !== '0) begin
        n_fails++;
        $display("FAIL rpost dut%0d: got %h/%h want 0/0", k, obs_stat(k), obs_head(k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      case (r % 3)
        0:       trig_mask = 32'hFFFF_FFFF;
        1:       trig_mask = 32'hFFFF_FFC0;
        default: trig_mask = (r == 5) ? 32'h0 : 32'h0000_00F0;
      endcase
      trig_addr = 32'($urandom_range(0, 63)) << 2;
      pulse_arm();
      for (int i = 0; i < 150; i++) begin
        ctrl_bus  = 32'($urandom_range(0, 3));
        addr_bus  = 32'($urandom_range(0, 63)) << 2;
        data_bus  = $urandom;
        cpu_sel   = 1'($urandom_range(0, 1));
        trc_ready = 1'($urandom_range(0, 1));
        arm       = ($urandom_range(0, 24) == 0);
        tick();
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (obs_stat(k) !== exp_stat(k) || obs_head(k) !== exp_head(k)) begin
            n_fails++;
            $display("FAIL rand r%0d c%0d dut%0d: got %h/%h want %h/%h", r, i, k, obs_stat(k),
                     obs_head(k), exp_stat(k), exp_head(k));
          end
        end
      end
      arm      = 1'b0;
      ctrl_bus = '0;
    end
    trc_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    arm       = 1'b0;
    cpu_sel   = 1'b0;
    trc_ready = 1'b0;
    trig_addr = '0;
    trig_mask = '0;
    addr_bus  = '0;
    data_bus  = '0;
    ctrl_bus  = '0;
    test_reset();
    test_trigger();
    test_drain();
    test_history();
    test_drain();
    test_post0();
    test_write_mask();
    test_drain();
    test_stall();
    test_reset_post();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
